// File: rtl/sigmoid_pipe_if.sv
// Ready/valid handshake bundle for sigmoid_pipe: sample in, result out.
// The producer/consumer side uses the master modport, the pipe uses slave.
interface sigmoid_pipe_if #(
    parameter int IW = 8,
    parameter int OW = 16
);
    logic          i_in_valid;
    logic          o_in_ready;
    logic [IW-1:0] i_x;
    logic          i_mode;
    logic [OW-1:0] o_y;
    logic          o_out_valid;
    logic          i_out_ready;

    modport master (
        output i_in_valid, i_x, i_mode, i_out_ready,
        input  o_in_ready, o_y, o_out_valid
    );

    modport slave (
        input  i_in_valid, i_x, i_mode, i_out_ready,
        output o_in_ready, o_y, o_out_valid
    );
endinterface

// File: rtl/sigmoid_pipe.sv
// Three-stage piecewise-linear sigmoid (optional tanh) with ready/valid flow control.
// Define SIGMOID_TANH_EN to build the i_mode-selected tanh path.
module sigmoid_pipe #(
    parameter int IW = 8,
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst,
    sigmoid_pipe_if.slave bus,
    output logic [50:0]   number
);
    localparam int FW  = IW - 3;
    localparam int PW  = FW + 5;
    localparam int AW  = IW - 1;
    localparam logic [AW-1:0] A_MAX  = '1;
    localparam logic [PW-1:0] P_HALF = PW'(1) << (PW - 1);
    localparam logic [PW-1:0] P_R1   = PW'(5) << (FW + 2);
    localparam logic [PW-1:0] P_R2   = PW'(27) << FW;

    // Transistor counts of the standard cells this block is built from.
    localparam int T_IV  = 2;
    localparam int T_ND2 = 4;
    localparam int T_ND3 = 6;
    localparam int T_AN2 = 6;
    localparam int T_MUX = 12;
    localparam int T_HA  = 14;
    localparam int T_FA  = 28;
    localparam int T_FD2 = 36;

    localparam int N_FF_BASE = 3 + AW + 2 + 1 + PW + 1 + OW;
    localparam int T_BASE =
        N_FF_BASE * (T_FD2 + T_MUX)
      + IW * (T_IV + T_HA + T_MUX) + AW * T_MUX + (T_IV + T_AN2)
      + PW * (2 * T_MUX + T_FA)
      + OW * (T_IV + T_HA + T_MUX)
      + (T_IV + T_ND2) + (2 * T_IV + T_ND3);

    typedef enum logic [1:0] {
        REG_R0,
        REG_R1,
        REG_R2
    } region_e;

    logic          advance;
    logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [AW-1:0] s1_a_q, s1_a_d;
    region_e       s1_reg_q, s1_reg_d;
    logic          s1_neg_q, s1_neg_d;
    logic [PW-1:0] s2_p_q, s2_p_d;
    logic          s2_neg_q, s2_neg_d;
    logic [OW-1:0] y_q, y_d;

    logic [IW-1:0] x_abs;
    logic [AW-1:0] a_sat, a_new;
    logic [OW-1:0] p_code, y_sig, y_new;

`ifdef SIGMOID_TANH_EN
    localparam int T_TANH = 2 * (T_FD2 + T_MUX) + AW * 2 * T_MUX + T_IV + T_MUX;
    logic s1_mode_q, s1_mode_d, s2_mode_q, s2_mode_d;
`else
    localparam int T_TANH = 0;
    logic mode_unused;
    assign mode_unused = bus.i_mode;
`endif

    assign number = 51'(T_BASE + T_TANH);

    // A full output slot that is not being drained freezes every stage.
    assign advance         = !v3_q || bus.i_out_ready;
    assign bus.o_in_ready  = rst || advance;
    assign bus.o_out_valid = v3_q;
    assign bus.o_y         = y_q;

    // Stage 1: magnitude with -4 clamp, optional doubling, region decode.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        x_abs = bus.i_x[IW-1] ? -bus.i_x : bus.i_x;
        a_sat = x_abs[IW-1] ? A_MAX : x_abs[AW-1:0];
        a_new = a_sat;
`ifdef SIGMOID_TANH_EN
        if (bus.i_mode) a_new = a_sat[AW-1] ? A_MAX : {a_sat[AW-2:0], 1'b0};
`endif
        s1_a_d   = s1_a_q;
        s1_reg_d = s1_reg_q;
        s1_neg_d = s1_neg_q;
`ifdef SIGMOID_TANH_EN
        s1_mode_d = s1_mode_q;
`endif
        if (advance) begin
            s1_a_d   = a_new;
            s1_reg_d = a_new[AW-1] ? REG_R2 : (a_new[AW-2] ? REG_R1 : REG_R0);
            s1_neg_d = bus.i_x[IW-1];
`ifdef SIGMOID_TANH_EN
            s1_mode_d = bus.i_mode;
`endif
        end
    end

    // Stage 2: segment slope is a pure shift, offset a constant add.
    always_comb begin
        s2_p_d   = s2_p_q;
        s2_neg_d = s2_neg_q;
`ifdef SIGMOID_TANH_EN
        s2_mode_d = s2_mode_q;
`endif
        if (advance) begin
            case (s1_reg_q)
                REG_R0:  s2_p_d = {s1_a_q, 3'b000} + P_HALF;
                REG_R1:  s2_p_d = {1'b0, s1_a_q, 2'b00} + P_R1;
                default: s2_p_d = PW'(s1_a_q) + P_R2;
            endcase
            s2_neg_d = s1_neg_q;
`ifdef SIGMOID_TANH_EN
            s2_mode_d = s1_mode_q;
`endif
        end
    end

    generate
        if (OW > PW) begin : g_pad
            assign p_code = {s2_p_q, {(OW - PW){1'b0}}};
        end else begin : g_trunc
            assign p_code = s2_p_q[PW-1 -: OW];
        end
    endgenerate

    // Stage 3: reflect for negative inputs; tanh re-centres by flipping the MSB.
    always_comb begin
        y_sig = s2_neg_q ? -p_code : p_code;
        y_new = y_sig;
`ifdef SIGMOID_TANH_EN
        if (s2_mode_q) y_new = {~y_sig[OW-1], y_sig[OW-2:0]};
`endif
        y_d  = advance ? y_new : y_q;
        v1_d = advance ? bus.i_in_valid : v1_q;
        v2_d = advance ? v1_q : v2_q;
        v3_d = advance ? v2_q : v3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            y_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            y_q  <= y_d;
        end
    end

    // NOTE: data stages carry no reset; their contents only matter behind a set valid bit.
    always_ff @(posedge clk) begin
        s1_a_q   <= s1_a_d;
        s1_reg_q <= s1_reg_d;
        s1_neg_q <= s1_neg_d;
        s2_p_q   <= s2_p_d;
        s2_neg_q <= s2_neg_d;
`ifdef SIGMOID_TANH_EN
        s1_mode_q <= s1_mode_d;
        s2_mode_q <= s2_mode_d;
`endif
    end
endmodule

// File: tb/tb_sigmoid_pipe.sv
// Self-checking bench for sigmoid_pipe: real-valued reference model, scoreboard and directed tests.
// Expectations for i_mode follow whether SIGMOID_TANH_EN is defined for the build.
module tb_sigmoid_pipe;
    localparam int IW = 8;
    localparam int OW = 16;
    localparam int FW = IW - 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [50:0] number;
    logic [50:0] num0;

    sigmoid_pipe_if #(.IW(IW), .OW(OW)) bus();

    sigmoid_pipe #(.IW(IW), .OW(OW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .number (number)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] x;
        logic          mode;
        logic [OW-1:0] y;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cycle    = 0;
    int            n_deliv  = 0;
    bit            lat_on   = 0;
    bit            stall_prev = 0;
    logic [OW-1:0] held_y;
    logic [OW-1:0] last_y;
    logic [OW-1:0] sweep_res [256];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: evaluate the piecewise curve on real numbers, then quantise.
    function automatic logic [OW-1:0] model(logic [IW-1:0] x, logic mode);
        real xv, a, p, amax;
        int  code, y;
        bit  use_tanh;
        xv   = real'($signed(x)) / real'(1 << FW);
        amax = 4.0 - 1.0 / real'(1 << FW);
        a    = (xv < 0.0) ? -xv : xv;
        if (a > amax) a = amax;
`ifdef SIGMOID_TANH_EN
        use_tanh = mode;
`else
        use_tanh = 1'b0;
`endif
        if (use_tanh) begin
            a = 2.0 * a;
            if (a > amax) a = amax;
        end
        if (a < 1.0)      p = a / 4.0 + 0.5;
        else if (a < 2.0) p = a / 8.0 + 0.625;
        else              p = a / 32.0 + 27.0 / 32.0;
        code = int'($floor(p * (2.0 ** OW)));
        y    = (xv >= 0.0) ? code : (1 << OW) - code;
        if (use_tanh) y = y - (1 << (OW - 1));
        return OW'(y);
    endfunction

    always @(posedge clk) cycle++;

    // Compare process: scoreboard, latency, hold-while-stalled, ready rule.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            sb.delete();
            stall_prev = 0;
        end else begin
            check("in_ready_rule", bus.o_in_ready, !bus.o_out_valid || bus.i_out_ready);
            if (stall_prev) begin
                check("stall_valid_hold", bus.o_out_valid, 1);
                check("stall_y_hold", bus.o_y, held_y);
            end
            if (bus.o_out_valid && bus.i_out_ready) begin
                check("output_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_deliv++;
                    check("y", bus.o_y, e.y);
                    if (lat_on) check("latency", cycle - e.cyc, 3);
                    if (!e.mode) sweep_res[e.x] = bus.o_y;
                    last_y = bus.o_y;
                end
            end
            if (bus.i_in_valid && bus.o_in_ready)
                sb.push_back('{bus.i_x, bus.i_mode, model(bus.i_x, bus.i_mode), cycle});
            stall_prev = bus.o_out_valid && !bus.i_out_ready;
            held_y     = bus.o_y;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(logic [IW-1:0] x, logic mode);
        bit accepted = 0;
        bus.i_in_valid = 1'b1;
        bus.i_x        = x;
        bus.i_mode     = mode;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            accepted = bus.o_in_ready;
            @(posedge clk);
            #1;
        end
        if (!accepted) check("accept_timeout", accepted, 1);
        bus.i_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [IW-1:0] t1_x [6] = '{8'h00, 8'h10, 8'h20, 8'hE0, 8'h40, 8'h80};
    logic [OW-1:0] t1_y [6] = '{16'h8000, 16'hA000, 16'hC000, 16'h4000, 16'hE800, 16'h0840};
    logic [IW-1:0] t2_x [3] = '{8'h10, 8'h00, 8'hF0};
`ifdef SIGMOID_TANH_EN
    logic [OW-1:0] t2_y [3] = '{16'h4000, 16'h0000, 16'hC000};
`else
    logic [OW-1:0] t2_y [3] = '{16'hA000, 16'h8000, 16'h6000};
`endif
    logic [IW-1:0] bp_x [5] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40};

    initial begin : main
        int idx;
        int d0;
        bus.i_in_valid  = 1'b0;
        bus.i_x         = '0;
        bus.i_mode      = 1'b0;
        bus.i_out_ready = 1'b1;
        rst             = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", bus.o_out_valid, 0);
        check("reset_y", bus.o_y, 0);
        check("reset_in_ready", bus.o_in_ready, 1);
        check("number_nonzero", number != 0, 1);
        num0 = number;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Spot values, back-to-back from the first cycle out of reset
        for (int i = 0; i < 6; i++) check("model_pin_sigmoid", model(t1_x[i], 1'b0), t1_y[i]);
        lat_on = 1;
        for (int i = 0; i < 6; i++) send(t1_x[i], 1'b0);
        wait_drain();
        check("spot_last_y", last_y, 16'h0840);

        // Mode input (tanh when enabled, ignored otherwise)
        for (int i = 0; i < 3; i++) check("model_pin_mode1", model(t2_x[i], 1'b1), t2_y[i]);
        for (int i = 0; i < 3; i++) send(t2_x[i], 1'b1);
        wait_drain();
        check("mode_last_y", last_y, t2_y[2]);

        // Backpressure: i_out_ready low for cycles 4..7
        lat_on = 0;
        d0  = n_deliv;
        idx = 0;
        for (int t = 1; t <= 12; t++) begin
            bus.i_out_ready = !(t >= 4 && t <= 7);
            bus.i_in_valid  = (idx < 5);
            bus.i_x         = (idx < 5) ? bp_x[idx] : '0;
            bus.i_mode      = 1'b0;
            @(negedge clk);
            if (t >= 4 && t <= 7) begin
                check("bp_in_ready_low", bus.o_in_ready, 0);
                check("bp_y_hold", bus.o_y, 16'h8000);
                check("bp_valid_hold", bus.o_out_valid, 1);
            end
            if (bus.i_in_valid && bus.o_in_ready) idx++;
            @(posedge clk);
            #1;
        end
        bus.i_in_valid  = 1'b0;
        bus.i_out_ready = 1'b1;
        wait_drain();
        check("bp_all_accepted", idx, 5);
        check("bp_delivered", n_deliv - d0, 5);

        // Sweep, both modes
        lat_on = 1;
        for (int m = 0; m < 2; m++)
            for (int v = 0; v < 256; v++) send(IW'(v), m[0]);
        wait_drain();
        for (int s = -128; s < 127; s++)
            check("monotonic", sweep_res[8'(s + 1)] >= sweep_res[8'(s)], 1);
        for (int v = 1; v < 128; v++)
            check("symmetry", 17'(sweep_res[v]) + 17'(sweep_res[256 - v]), 17'h10000);
        check("sweep_zero", sweep_res[0], 16'h8000);

        // Reset mid-stream with three samples in flight and output stalled
        lat_on = 0;
        bus.i_out_ready = 1'b0;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        rst            = 1'b1;
        bus.i_in_valid = 1'b1;
        bus.i_x        = 8'h40;
        @(negedge clk);
        check("rst_in_ready", bus.o_in_ready, 1);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.i_in_valid  = 1'b0;
        bus.i_out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", bus.o_out_valid, 0);
        check("rst_mid_y", bus.o_y, 0);
        @(posedge clk);
        #1;
        last_y = '0;
        d0     = n_deliv;
        lat_on = 1;
        send(8'h20, 1'b0);
        wait_drain();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("post_reset_y", last_y, 16'hC000);
        check("post_reset_count", n_deliv - d0, 1);

        check("number_const", number, num0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sigmoid_pipe.md
# sigmoid_pipe

Parametrised, pipelined piecewise-linear sigmoid unit, the successor to the 8-bit sigmoid block. Accepts a signed fixed-point sample and returns an unsigned fixed-point sigmoid over a three-stage ready/valid pipeline. An optional compile-time tanh mode is available. Built from the team's standard cells (FD2, MUX21H, ND2/ND3, IV, AN2 and adders) and reports its transistor count on `number` like every other block.

## Interface
- `IW`, 8: input width; signed two's complement; 1 sign, 2 integer and `FW = IW-3` fraction bits (range -4 .. 4-2^-FW); IW >= 5
- `OW`, 16: output width; unsigned Q0.OW (tanh: signed Q1.(OW-1)); OW >= 6
- `clk` input 1: single clock; all state updates on rising edge
- `rst` input 1: synchronous, active-high reset
- `i_in_valid` input 1: input sample valid
- `o_in_ready` output 1: block accepts a sample this cycle
- `i_x` input IW: input sample
- `i_mode` input 1: 0 = sigmoid, 1 = tanh; sampled with `i_x`
- `o_y` output OW: result
- `o_out_valid` output 1: `o_y` valid
- `i_out_ready` input 1: downstream accepts `o_y`
- `number` output 51: constant sum of transistor counts of all instantiated cells

## Operation
- Internal precision: FW+5 fraction bits, exact for all segments. Result is truncated to OW bits, or zero-padded when OW > FW+5.
- S1 (register 1):
  - a = |x|; x = -4 clamps to a = 4-2^-FW.
  - tanh mode: a = min(2a, 4-2^-FW).
  - Region decode: R0 a<1, R1 1<=a<2, R2 a>=2.
  - Sign and mode are carried forward.
- S2 (register 2): p = a/4+1/2 (R0), a/8+5/8 (R1), a/32+27/32 (R2). Shift-and-add only, no multiplier. p < 1 always.
- S3 (register 3, drives `o_y`):
  - Sigmoid: y = p code if x >= 0, else 2^OW - p code.
  - Tanh: compute the sigmoid code, then subtract 2^(OW-1); interpret the result as two's complement.
- x = 0 always yields exactly 0.5 (0x8000 for OW=16); tanh yields 0.
- Handshake:
  - advance = !o_out_valid | i_out_ready; o_in_ready = advance (combinational).
  - When advance is 1, all three stages shift and the S1 valid bit loads i_in_valid. When 0, all stages hold.
  - Bubbles are not collapsed.
- A sample is accepted iff i_in_valid & o_in_ready.
- A sample is delivered iff o_out_valid & i_out_ready.
- No sample is lost or duplicated under any ready pattern.

## Timing
- Latency: 3 cycles from acceptance to o_out_valid, with i_out_ready held high.
- Throughput: 1 sample/cycle when i_out_ready is high.
- Reset (synchronous): all stage valid bits cleared, o_out_valid=0, o_y=0.
  - During reset o_in_ready=1, but samples presented in reset cycles are discarded.
  - Reset mid-stream drops all in-flight samples.
  - First acceptance is possible on the first cycle after rst deasserts.
- Output stability: o_y and o_out_valid hold stable while o_out_valid=1 & i_out_ready=0.
- Simultaneous deliver and accept in the same cycle is legal and keeps full rate.
- Data registers may load X-free garbage when their valid bit is 0; o_y is only meaningful when o_out_valid=1.

## Configuration
- `SIGMOID_TANH_EN` defined:
  - i_mode selects tanh as described.
  - The S1 doubling/clamp and S3 offset subtract are instantiated and included in `number`.
- Not defined:
  - i_mode port remains but is ignored; the block computes sigmoid only.
  - No tanh cells are instantiated, so `number` is smaller.

## Test plan
1. Spot values, IW=8, OW=16, sigmoid, ready high, back-to-back inputs:
   - 0x00 -> 0x8000
   - 0x10 -> 0xA000
   - 0x20 -> 0xC000
   - 0xE0 -> 0x4000
   - 0x40 -> 0xE800
   - 0x80 -> 0x0840
   - Each output appears exactly 3 cycles after acceptance.
2. Tanh (SIGMOID_TANH_EN): 0x10 with i_mode=1 -> 0x4000; 0x00 -> 0x0000; 0xF0 -> 0xC000. Without the macro, the same stimulus yields the sigmoid codes 0xA000, 0x8000, 0x6000.
3. Backpressure: stream 0x00,0x10,0x20,0x30,0x40 with i_out_ready low cycles 4-7.
   - o_in_ready drops while stalled.
   - o_y holds 0x8000 during the stall.
   - All 5 results are delivered in order, with none lost or duplicated.
4. Sweep: all 256 inputs in both modes, compared against a bit-exact reference model.
   - Sigmoid output is monotonic non-decreasing in x.
   - y(x) + y(-x) = 0x10000 for x != -4.
5. Reset mid-stream: assert rst for 1 cycle with 3 samples in flight.
   - o_out_valid=0 and o_y=0 the next cycle.
   - No stale output appears afterwards.
   - A new sample 0x20 yields 0xC000 three cycles after acceptance.
6. `number` is constant and non-zero, and differs between builds with and without SIGMOID_TANH_EN.
